// File: rtl/apb_arbiter_pkg.sv
// Shared definitions for the two-master APB arbiter: FSM encoding,
// master indices and the default watchdog limit.
package apb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/apb_arbiter_watchdog.sv
// ACCESS-phase watchdog: counts stalled cycles and flags expiry on the
// TIMEOUT-th one. A TIMEOUT of 0 disables expiry entirely.
module apb_watchdog
    import apb_arbiter_pkg::*;
#(
    parameter int TIMEOUT  = DEFAULT_TIMEOUT,
    parameter int TO_WIDTH = 8
) (
    input  logic clk,
    input  logic rts,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam bit                  ENABLED = (TIMEOUT != 0);
    localparam logic [TO_WIDTH-1:0] LIMIT   = TO_WIDTH'(TIMEOUT - 1);

    logic [TO_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rts) begin
        if (!rts) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = ENABLED && enable && (count == LIMIT);

endmodule

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one downstream APB bus between two masters,
// regenerating SETUP/ACCESS phases and aborting hung transfers.
module apb_arbiter
    import apb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int TO_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rts,

    input  logic [ADDR_WIDTH-1:0]   m0_paddr,
    input  logic [DATA_WIDTH-1:0]   m0_pdata,
    input  logic                    m0_psel,
    input  logic                    m0_penable,
    input  logic                    m0_pwrite,
    input  logic [DATA_WIDTH/8-1:0] m0_pstb,
    output logic [DATA_WIDTH-1:0]   m0_prdata,
    output logic                    m0_pready,
    output logic                    m0_perr,

    input  logic [ADDR_WIDTH-1:0]   m1_paddr,
    input  logic [DATA_WIDTH-1:0]   m1_pdata,
    input  logic                    m1_psel,
    input  logic                    m1_penable,
    input  logic                    m1_pwrite,
    input  logic [DATA_WIDTH/8-1:0] m1_pstb,
    output logic [DATA_WIDTH-1:0]   m1_prdata,
    output logic                    m1_pready,
    output logic                    m1_perr,

    output logic [ADDR_WIDTH-1:0]   apb_paddr,
    output logic [DATA_WIDTH-1:0]   apb_pdata,
    output logic [DATA_WIDTH/8-1:0] apb_pstb,
    output logic                    apb_pwrite,
    output logic                    apb_psel,
    output logic                    apb_penable,
    input  logic [DATA_WIDTH-1:0]   apb_prdata,
    input  logic                    apb_pready,
    input  logic                    apb_perr,

    output logic [1:0]              grant,
    output logic                    timeout
);

    arb_state_t state;
    logic       owner;
    logic       last_grant;
    logic       winner;
    logic       expire;
    logic       done_ok;
    logic       wd_fire;

    // Master penable is implied by the arbiter's own phase sequencing.
    logic unused_penable;
    assign unused_penable = &{1'b0, m0_penable, m1_penable};

    always_comb begin
        winner = M0;
        if (m0_psel && m1_psel) begin
            winner = ~last_grant;
        end else if (m1_psel) begin
            winner = M1;
        end
    end

    always_ff @(posedge clk or negedge rts) begin
        if (!rts) begin
            state       <= IDLE;
            grant       <= 2'b00;
            owner       <= M0;
            last_grant  <= M1;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m0_psel || m1_psel) begin
                        state       <= SETUP;
                        owner       <= winner;
                        grant       <= (winner == M1) ? 2'b10 : 2'b01;
                        apb_psel    <= 1'b1;
                        apb_penable <= 1'b0;
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    apb_penable <= 1'b1;
                end
                ACCESS: begin
                    if (done_ok || wd_fire) begin
                        state       <= IDLE;
                        grant       <= 2'b00;
                        last_grant  <= owner;
                        apb_psel    <= 1'b0;
                        apb_penable <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant       <= 2'b00;
                    apb_psel    <= 1'b0;
                    apb_penable <= 1'b0;
                end
            endcase
        end
    end

    apb_watchdog #(
        .TIMEOUT  (TIMEOUT),
        .TO_WIDTH (TO_WIDTH)
    ) u_watchdog (
        .clk    (clk),
        .rts    (rts),
        .clear  (state == SETUP),
        .enable ((state == ACCESS) && !apb_pready),
        .expire (expire)
    );

    // Normal completion wins over a watchdog expiry landing in the same cycle.
    assign done_ok = (state == ACCESS) && apb_pready;
    assign wd_fire = (state == ACCESS) && !apb_pready && expire;
    assign timeout = wd_fire;

    always_comb begin
        apb_paddr  = '0;
        apb_pdata  = '0;
        apb_pstb   = '0;
        apb_pwrite = 1'b0;
        if (state != IDLE) begin
            if (owner == M1) begin
                apb_paddr  = m1_paddr;
                apb_pdata  = m1_pdata;
                apb_pstb   = m1_pstb;
                apb_pwrite = m1_pwrite;
            end else begin
                apb_paddr  = m0_paddr;
                apb_pdata  = m0_pdata;
                apb_pstb   = m0_pstb;
                apb_pwrite = m0_pwrite;
            end
        end
    end

    always_comb begin
        m0_pready = 1'b0;
        m0_perr   = 1'b0;
        m0_prdata = '0;
        m1_pready = 1'b0;
        m1_perr   = 1'b0;
        m1_prdata = '0;
        if (owner == M1) begin
            m1_pready = done_ok || wd_fire;
            m1_perr   = done_ok ? apb_perr : wd_fire;
            m1_prdata = done_ok ? apb_prdata : '0;
        end else begin
            m0_pready = done_ok || wd_fire;
            m0_perr   = done_ok ? apb_perr : wd_fire;
            m0_prdata = done_ok ? apb_prdata : '0;
        end
    end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed self-checking bench for apb_arbiter with a short watchdog limit.
module tb_apb_arbiter;

    logic        clk = 1'b0;
    logic        rts = 1'b0;

    logic [31:0] m0_paddr = '0, m0_pdata = '0, m0_prdata;
    logic        m0_psel = 1'b0, m0_penable = 1'b0, m0_pwrite = 1'b0;
    logic [3:0]  m0_pstb = '0;
    logic        m0_pready, m0_perr;

    logic [31:0] m1_paddr = '0, m1_pdata = '0, m1_prdata;
    logic        m1_psel = 1'b0, m1_penable = 1'b0, m1_pwrite = 1'b0;
    logic [3:0]  m1_pstb = '0;
    logic        m1_pready, m1_perr;

    logic [31:0] apb_paddr, apb_pdata;
    logic [3:0]  apb_pstb;
    logic        apb_pwrite, apb_psel, apb_penable;
    logic [31:0] apb_prdata = '0;
    logic        apb_pready;
    logic        apb_perr = 1'b0;
    logic        slave_ready = 1'b0;

    logic [1:0]  grant;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    logic [1:0] rr_expected [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    always #5 clk = ~clk;

    // Slave answers only during the downstream ACCESS phase.
    assign apb_pready = slave_ready & apb_penable;

    apb_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (4),
        .TO_WIDTH   (8)
    ) dut (
        .clk         (clk),
        .rts         (rts),
        .m0_paddr    (m0_paddr),
        .m0_pdata    (m0_pdata),
        .m0_psel     (m0_psel),
        .m0_penable  (m0_penable),
        .m0_pwrite   (m0_pwrite),
        .m0_pstb     (m0_pstb),
        .m0_prdata   (m0_prdata),
        .m0_pready   (m0_pready),
        .m0_perr     (m0_perr),
        .m1_paddr    (m1_paddr),
        .m1_pdata    (m1_pdata),
        .m1_psel     (m1_psel),
        .m1_penable  (m1_penable),
        .m1_pwrite   (m1_pwrite),
        .m1_pstb     (m1_pstb),
        .m1_prdata   (m1_prdata),
        .m1_pready   (m1_pready),
        .m1_perr     (m1_perr),
        .apb_paddr   (apb_paddr),
        .apb_pdata   (apb_pdata),
        .apb_pstb    (apb_pstb),
        .apb_pwrite  (apb_pwrite),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_prdata  (apb_prdata),
        .apb_pready  (apb_pready),
        .apb_perr    (apb_perr),
        .grant       (grant),
        .timeout     (timeout)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s0, input logic e0, input logic s1, input logic e1, input logic rdy);
        m0_psel     = s0;
        m0_penable  = e0;
        m1_psel     = s1;
        m1_penable  = e1;
        slave_ready = rdy;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic doReset();
        rts = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apb_perr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rts = 1'b1;
    endtask

    initial begin
        // Reset state
        #3;
        checkBit("rst_psel", apb_psel, 1'b0);
        checkBit("rst_penable", apb_penable, 1'b0);
        checkOutput("rst_grant", {30'b0, grant}, 32'h0);
        checkBit("rst_timeout", timeout, 1'b0);
        checkBit("rst_m0_pready", m0_pready, 1'b0);
        checkBit("rst_m1_pready", m1_pready, 1'b0);
        checkOutput("rst_paddr", apb_paddr, 32'h0);

        // Single zero-wait read by m0
        doReset();
        m0_paddr   = 32'h0000_0010;
        m0_pwrite  = 1'b0;
        m0_pstb    = 4'h0;
        apb_prdata = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checkBit("t1_idle_psel", apb_psel, 1'b0);
        checkOutput("t1_idle_paddr", apb_paddr, 32'h0);
        cycle();
        m0_penable = 1'b1;
        settle();
        checkBit("t1_setup_psel", apb_psel, 1'b1);
        checkBit("t1_setup_penable", apb_penable, 1'b0);
        checkOutput("t1_setup_grant", {30'b0, grant}, 32'h1);
        checkOutput("t1_setup_paddr", apb_paddr, 32'h0000_0010);
        checkBit("t1_setup_m0_pready", m0_pready, 1'b0);
        cycle();
        settle();
        checkBit("t1_access_penable", apb_penable, 1'b1);
        checkOutput("t1_access_grant", {30'b0, grant}, 32'h1);
        checkBit("t1_access_m0_pready", m0_pready, 1'b1);
        checkOutput("t1_access_m0_prdata", m0_prdata, 32'hDEAD_BEEF);
        checkBit("t1_access_m0_perr", m0_perr, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checkBit("t1_done_psel", apb_psel, 1'b0);
        checkOutput("t1_done_grant", {30'b0, grant}, 32'h0);
        checkBit("t1_done_m0_pready", m0_pready, 1'b0);

        // Simultaneous requests from reset: m0 first, then m1
        doReset();
        m0_paddr  = 32'h0000_0100;
        m1_paddr  = 32'h0000_0200;
        m1_pdata  = 32'hCAFE_F00D;
        m1_pwrite = 1'b1;
        m1_pstb   = 4'hF;
        apb_prdata = 32'h1111_2222;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        settle();
        checkOutput("t2_m0_grant", {30'b0, grant}, 32'h1);
        checkOutput("t2_m0_paddr", apb_paddr, 32'h0000_0100);
        cycle();
        settle();
        checkBit("t2_m0_pready", m0_pready, 1'b1);
        checkBit("t2_m1_stalled", m1_pready, 1'b0);
        checkOutput("t2_m1_prdata_zero", m1_prdata, 32'h0);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        checkOutput("t2_idle_grant", {30'b0, grant}, 32'h0);
        checkBit("t2_idle_m1_pready", m1_pready, 1'b0);
        cycle();
        settle();
        checkOutput("t2_m1_grant", {30'b0, grant}, 32'h2);
        checkOutput("t2_m1_paddr", apb_paddr, 32'h0000_0200);
        checkBit("t2_m1_pwrite", apb_pwrite, 1'b1);
        cycle();
        settle();
        checkBit("t2_m1_pready", m1_pready, 1'b1);
        checkOutput("t2_m1_pdata", apb_pdata, 32'hCAFE_F00D);
        checkOutput("t2_m1_pstb", {28'b0, apb_pstb}, 32'hF);
        checkOutput("t2_m1_prdata", m1_prdata, 32'h1111_2222);
        checkBit("t2_m0_idle_pready", m0_pready, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        m1_pwrite = 1'b0;
        m1_pstb   = 4'h0;

        // Continuous requests from both: alternating grants
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int t = 0; t < 6; t++) begin
            cycle();
            settle();
            checkOutput($sformatf("t3_grant_%0d", t), {30'b0, grant}, {30'b0, rr_expected[t]});
            cycle();
            cycle();
            settle();
            checkOutput($sformatf("t3_idle_%0d", t), {30'b0, grant}, 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Hung slave with TIMEOUT=4
        doReset();
        m0_paddr   = 32'h0000_0040;
        apb_prdata = 32'h1234_5678;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        m0_penable = 1'b1;
        for (int a = 1; a <= 3; a++) begin
            cycle();
            settle();
            checkBit($sformatf("t4_access%0d_pready", a), m0_pready, 1'b0);
            checkBit($sformatf("t4_access%0d_timeout", a), timeout, 1'b0);
        end
        cycle();
        settle();
        checkBit("t4_expire_pready", m0_pready, 1'b1);
        checkBit("t4_expire_perr", m0_perr, 1'b1);
        checkOutput("t4_expire_prdata", m0_prdata, 32'h0);
        checkBit("t4_expire_timeout", timeout, 1'b1);
        checkBit("t4_expire_psel", apb_psel, 1'b1);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        checkBit("t4_after_psel", apb_psel, 1'b0);
        checkBit("t4_after_timeout", timeout, 1'b0);
        checkOutput("t4_after_grant", {30'b0, grant}, 32'h0);

        // pready with perr exactly on the expiry cycle
        doReset();
        m1_paddr   = 32'h0000_0080;
        apb_prdata = 32'hA5A5_0001;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        m1_penable = 1'b1;
        repeat (3) cycle();
        cycle();
        slave_ready = 1'b1;
        apb_perr    = 1'b1;
        settle();
        checkBit("t5_pready", m1_pready, 1'b1);
        checkBit("t5_perr", m1_perr, 1'b1);
        checkBit("t5_timeout", timeout, 1'b0);
        checkOutput("t5_prdata", m1_prdata, 32'hA5A5_0001);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apb_perr = 1'b0;
        settle();
        checkBit("t5_after_timeout", timeout, 1'b0);
        checkBit("t5_after_psel", apb_psel, 1'b0);

        // Reset asserted during ACCESS, then a clean retry
        doReset();
        m0_paddr   = 32'h0000_0020;
        apb_prdata = 32'h0BAD_CAFE;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        m0_penable = 1'b1;
        cycle();
        settle();
        checkBit("t6_access_penable", apb_penable, 1'b1);
        #1;
        rts = 1'b0;
        #1;
        checkBit("t6_rst_psel", apb_psel, 1'b0);
        checkBit("t6_rst_penable", apb_penable, 1'b0);
        checkOutput("t6_rst_grant", {30'b0, grant}, 32'h0);
        checkBit("t6_rst_m0_pready", m0_pready, 1'b0);
        cycle();
        rts = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checkBit("t6_idle_psel", apb_psel, 1'b0);
        cycle();
        m0_penable = 1'b1;
        settle();
        checkBit("t6_setup_psel", apb_psel, 1'b1);
        checkBit("t6_setup_penable", apb_penable, 1'b0);
        checkOutput("t6_setup_grant", {30'b0, grant}, 32'h1);
        cycle();
        settle();
        checkBit("t6_access_pready", m0_pready, 1'b1);
        checkOutput("t6_access_prdata", m0_prdata, 32'h0BAD_CAFE);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
